handshake_rx: RTL and testbench

HANDSHAKE_RX -- requirements
Module: handshake_rx

---
 rtl/handshake_pkg.sv | 13 +
 rtl/cdc_sync.sv | 20 ++
 rtl/handshake_rx.sv | 67 ++++++
 tb/tb_handshake_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types and constants for the 4-phase handshake receiver and its transmitter twin.
`timescale 1ns/1ps
package handshake_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    VALID    = 2'd2,
    ACK      = 2'd3
  } hs_rx_state_t;
endpackage

// File: rtl/cdc_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset level.
`timescale 1ns/1ps
module cdc_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {DEPTH{RST_VAL}};
    else        sync_q <= {sync_q[DEPTH-2:0], d};
  end

  assign q = sync_q[DEPTH-1];
endmodule

// File: rtl/handshake_rx.sv
// 4-phase request/acknowledge receiver: synchronizes req, captures the word,
// presents it with valid/ready downstream and acknowledges once it is taken.
`timescale 1ns/1ps
module handshake_rx
  import handshake_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_rx,
  input  logic                  rst_n,
  input  logic                  req_async,
  input  logic [DATA_W-1:0]     data_async,
  output logic                  ack,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [XFER_CNT_W-1:0] xfer_count,
  output logic                  proto_err
);
  hs_rx_state_t state;
  logic         req_s;

  // Synchronizer resets high so a req left asserted across reset is ignored
  // until it has been seen low (state starts in WAIT_LOW).
  cdc_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_req_sync (
    .clk   (clk_rx),
    .rst_n (rst_n),
    .d     (req_async),
    .q     (req_s)
  );

  always_ff @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOW;
      ack        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      xfer_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        WAIT_LOW: if (!req_s) state <= IDLE;
        IDLE: if (req_s) begin
          // data_async is stable while req is high, so it is sampled directly.
          out_data  <= data_async;
          out_valid <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (!req_s) proto_err <= 1'b1;
          if (out_ready) begin
            out_valid  <= 1'b0;
            ack        <= 1'b1;
            xfer_count <= xfer_count + 1'b1;
            state      <= ACK;
          end
        end
        ACK: if (!req_s) begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end
endmodule

// File: tb/tb_handshake_rx.sv
// Directed bench for handshake_rx: latency, backpressure, stream, violation, reset and wrap.
`timescale 1ns/1ps
module tb_handshake_rx;
  localparam int DW = 32;
  localparam int SS = 2;

  logic          clk_rx = 1'b0;
  logic          clk_tx = 1'b0;
  logic          rst_n;
  logic          req_async;
  logic [DW-1:0] data_async;
  logic          ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [15:0]   xfer_count;
  logic          proto_err;

  int n_asrt = 0;
  int n_fail = 0;
  logic [DW-1:0] acc_q[$];
  bit stream_done;

  always #6.25 clk_rx = ~clk_rx;
  always #3.33 clk_tx = ~clk_tx;

  handshake_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk_rx     (clk_rx),
    .rst_n      (rst_n),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .xfer_count (xfer_count),
    .proto_err  (proto_err)
  );

  // Independent record of every word handed downstream.
  always @(posedge clk_rx)
    if (out_valid && out_ready) acc_q.push_back(out_data);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rx(input string tag, input logic want_valid, input logic want_ack);
    int n;
    n = 0;
    while (!((want_valid && out_valid) || (want_ack && ack) || (!want_valid && !want_ack && !ack))
           && n < 200) begin
      @(posedge clk_rx); #1; n++;
    end
    check({tag, "_timeout"}, 64'(n < 200), 64'd1);
  endtask

  task automatic tx_word(input logic [DW-1:0] d, input string tag);
    int n;
    @(posedge clk_tx);
    data_async = d;
    req_async  = 1'b1;
    n = 0;
    while (!ack && n < 400) begin @(negedge clk_tx); n++; end
    check({tag, "_ack_hi"}, 64'(ack), 64'd1);
    @(posedge clk_tx);
    req_async = 1'b0;
    n = 0;
    while (ack && n < 400) begin @(negedge clk_tx); n++; end
    check({tag, "_ack_lo"}, 64'(ack), 64'd0);
  endtask

  initial begin
    int n;
    bit seen_valid;
    rst_n = 1'b0; req_async = 1'b0; data_async = '0; out_ready = 1'b0;
    #20;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_xfer_count", 64'(xfer_count), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    #17 rst_n = 1'b1;
    repeat (5) @(negedge clk_rx);

    // Single word: latency SS+1 edges, valid for one cycle, ack falls 2..3 edges after req.
    data_async = 32'hA5A5_0001; req_async = 1'b1; out_ready = 1'b1;
    n = 0;
    do begin @(posedge clk_rx); #1; n++; end while (!out_valid && n < 20);
    check("single_latency", 64'(n), 64'(SS + 1));
    check("single_data", 64'(out_data), 64'hA5A5_0001);
    check("single_ack_before", 64'(ack), 64'd0);
    @(posedge clk_rx); #1;
    check("single_valid_1cyc", 64'(out_valid), 64'd0);
    check("single_ack_rise", 64'(ack), 64'd1);
    check("single_count", 64'(xfer_count), 64'd1);
    @(negedge clk_rx); req_async = 1'b0;
    n = 0;
    do begin @(posedge clk_rx); #1; n++; end while (ack && n < 20);
    check("single_ack_fall_2to3", 64'(n >= 2 && n <= 3), 64'd1);

    // Backpressure: hold out_ready low for 10 cycles.
    @(negedge clk_rx);
    out_ready = 1'b0; data_async = 32'h0000_0002; req_async = 1'b1;
    wait_rx("bp_valid", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_rx); #1;
      check($sformatf("bp_hold%0d", i), {31'd0, out_valid, ack, out_data},
            {31'd0, 1'b1, 1'b0, 32'h0000_0002});
    end
    @(negedge clk_rx); out_ready = 1'b1;
    @(posedge clk_rx); #1;
    check("bp_ack_rise", 64'(ack), 64'd1);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    @(negedge clk_rx); req_async = 1'b0;
    wait_rx("bp_ack_low", 1'b0, 1'b0);
    check("bp_count", 64'(xfer_count), 64'd2);

    // Stream: 1000 back-to-back transfers with random downstream readiness.
    acc_q.delete();
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) tx_word(32'h1000_0000 + i, "stream");
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk_rx);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    check("stream_size", 64'(acc_q.size()), 64'd1000);
    for (int i = 0; i < acc_q.size() && i < 1000; i++)
      if (acc_q[i] !== 32'h1000_0000 + i) check($sformatf("stream_word%0d", i), 64'(acc_q[i]), 64'(32'h1000_0000 + i));
    check("stream_order_ok", 64'(acc_q.size() == 1000), 64'd1);
    check("stream_count", 64'(xfer_count), 64'd1002);
    check("stream_proto_err", 64'(proto_err), 64'd0);

    // Violation: req drops while the word waits in VALID.
    @(negedge clk_rx);
    out_ready = 1'b0; data_async = 32'hDEAD_0003; req_async = 1'b1;
    wait_rx("viol_valid", 1'b1, 1'b0);
    @(negedge clk_rx); req_async = 1'b0;
    repeat (4) @(posedge clk_rx); #1;
    check("viol_proto_err", 64'(proto_err), 64'd1);
    check("viol_still_valid", 64'(out_valid), 64'd1);
    check("viol_data", 64'(out_data), 64'hDEAD_0003);
    @(negedge clk_rx); out_ready = 1'b1;
    @(posedge clk_rx); #1;
    check("viol_ack", 64'(ack), 64'd1);
    @(posedge clk_rx); #1;
    check("viol_ack_fall", 64'(ack), 64'd0);
    check("viol_count", 64'(xfer_count), 64'd1003);
    check("viol_delivered", 64'(acc_q[$]), 64'hDEAD_0003);
    repeat (3) @(posedge clk_rx); #1;
    check("viol_sticky", 64'(proto_err), 64'd1);

    // Reset with req held high: nothing delivered until req toggles.
    @(negedge clk_rx);
    data_async = 32'hBEEF_0004; req_async = 1'b1; out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #37;
    check("rr_proto_err_clr", 64'(proto_err), 64'd0);
    check("rr_count_clr", 64'(xfer_count), 64'd0);
    rst_n = 1'b1;
    acc_q.delete();
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_rx); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("rr_no_valid", 64'(seen_valid), 64'd0);
    @(negedge clk_rx); req_async = 1'b0;
    repeat (6) @(posedge clk_rx); #1;
    check("rr_none_yet", 64'(acc_q.size()), 64'd0);
    tx_word(32'hBEEF_0005, "rr");
    repeat (4) @(posedge clk_rx); #1;
    check("rr_one_word", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() > 0) check("rr_word", 64'(acc_q[0]), 64'hBEEF_0005);
    check("rr_count", 64'(xfer_count), 64'd1);

    // Counter wrap.
    @(negedge clk_rx); force dut.xfer_count = 16'hFFFF;
    @(negedge clk_rx); release dut.xfer_count;
    tx_word(32'h0000_FFFF, "wrap");
    #1;
    check("wrap_count", 64'(xfer_count), 64'd0);
    check("wrap_no_err", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
